exec_alu_muldiv: RTL and testbench
==================================

# exec_alu_muldiv

Parametrised execute-stage ALU that merges ALU-control decode with the datapath and adds multi-cycle RV32M-style multiply/divide. Sits in the EX stage between ID/EX and EX/MEM. Simple ops complete in 1 cycle; mul/div iterate 1 bit per cycle and stall the pipeline via `ready_o`.

## Interface

- `XLEN`, default 32: operand/result width; must be a power of 2, ≥ 8.
- `SHW`, default `$clog2(XLEN)`: shift-amount width, taken from `src2_i[SHW-1:0]`.

- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `valid_i`, input, 1: operation offered; accepted when `valid_i & ready_o`.
- `ALUOp_i`, input, 2: main-control op class.
- `funct_i`, input, 10: `{funct7, funct3}`.
- `src1_i`, input, XLEN: operand A.
- `src2_i`, input, XLEN: operand B or immediate.
- `flush_i`, input, 1: abort any in-flight op; no result is produced.
- `ready_o`, output, 1: unit can accept this cycle; high only in IDLE.
- `valid_o`, output, 1: `result_o` valid, one-cycle pulse.
- `result_o`, output, XLEN: registered result.
- `zero_o`, output, 1: `result_o == 0`, qualified by `valid_o`.

## Operation

- Decode `ALUOp_i`:
  - `00` → add.
  - `01` → sub (branch compare).
  - `11` → `funct[2:0]`: `000` addi, `101` srai, else nop.
  - `10` → full funct:
    - `0000000_111` and, `_100` xor, `_001` sll, `_000` add.
    - `0100000_000` sub.
    - `0000001_000` mul, `_100` div, `_101` divu, `_110` rem, `_111` remu.
    - Else nop.
- Nop produces result 0 and still pulses `valid_o`.
- Arithmetic:
  - add/sub/mul wrap modulo 2^XLEN; mul returns the low XLEN bits.
  - sll/srai use `src2_i[SHW-1:0]`; srai is arithmetic.
- Signed div/rem operate on magnitudes; the sign is fixed after the last iteration:
  - quotient is negative iff operand signs differ;
  - remainder takes the dividend's sign.
- Special cases resolve in 1 cycle, with no iteration:
  - divide by zero → quotient all-ones, remainder = dividend;
  - signed overflow (`-2^(XLEN-1) / -1`) → quotient = dividend, remainder 0.
- States:
  - IDLE: `ready_o=1`. Accept simple op or special case → DONE. Accept mul → MUL. Accept div-class → DIV.
  - MUL: shift-add, one multiplier bit per cycle, counter XLEN-1 down to 0. Count 0 → DONE.
  - DIV: restoring division, one quotient bit per cycle, XLEN iterations. Count 0 → DONE.
  - DONE: `valid_o=1`, `result_o` stable → IDLE.
- `flush_i` in any state → IDLE next cycle, `valid_o` stays 0. `flush_i` wins over a simultaneous `valid_i`, which is not accepted.
- Reset values: state IDLE, `ready_o=1`, `valid_o=0`, `result_o=0`, `zero_o=1`, counter 0.
- Reset mid-operation discards the op immediately.

## Timing

- Simple ops and special-case div: accept at edge N, `valid_o` high cycle N+1.
- mul: `valid_o` at N+XLEN+1.
- div/divu/rem/remu: `valid_o` at N+XLEN+1, fixed and data-independent.
- `ready_o` is low from the cycle after an accept until DONE completes. Back-to-back simple ops therefore issue every 2 cycles.
- Operands and decoded op are captured at accept. Later changes to inputs are ignored.
- `result_o` holds its last value outside DONE.

## Structure

- Shared package `exec_pkg`:
  - `alu_op_e`, 4-bit enum: NOP, AND, XOR, SLL, ADD, SUB, SRA, MUL, DIV, DIVU, REM, REMU.
  - ALUOp constants `ALUOP_LS=2'b00`, `ALUOP_BR=2'b01`, `ALUOP_R=2'b10`, `ALUOP_I=2'b11`.
  - funct constants.
  - State enum `ex_state_e`.
- Sub-module `alu_op_decode`: combinational, `ALUOp_i`/`funct_i` → `alu_op_e`. Replaces the old 3-bit control encoding.
- The top block holds the FSM, simple-op datapath and iterative mul/div engines.

## Test plan

- Reset asserted mid-DIV → `valid_o=0`, `ready_o=1`, `result_o=0` immediately. After release, `add 5+7` → `valid_o` next cycle, `result_o=12`.
- `ALUOp=10`, funct `0100000_000`, `3-5` → `result_o=32'hFFFFFFFE` at N+1. `ALUOp=01`, `9-9` → `zero_o=1`.
- mul `0x10000 × 0x10001` → `result_o=0x00010000` at exactly N+33, `ready_o=0` for cycles N+1..N+32.
- Division cases, each with `valid_o` at N+33:
  - div `-7/2` → quotient `-3`;
  - rem `-7/2` → `-1`;
  - divu `0xFFFFFFFF/16` → `0x0FFFFFFF`;
  - remu `100/7` → `2`.
- Special cases, each with `valid_o` at N+1:
  - div `x/0` → `0xFFFFFFFF`;
  - rem `x/0` → `x`;
  - div `0x80000000/-1` → `0x80000000`;
  - rem of the same → `0`.
- `flush_i` at cycle N+10 of a mul → IDLE next cycle, no `valid_o` pulse. `flush_i` together with `valid_i` → op not accepted.

Source files
------------

// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute-stage ALU with iterative multiply/divide.
//   alu_op_e    : decoded operation, produced by alu_op_decode
//   ALUOP_*     : main-control op-class encodings
//   F7_* / F3_* : funct7 / funct3 field values
//   FN_*        : full {funct7, funct3} codes for R-type decode
//   ex_state_e  : execute FSM states
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_AND  = 4'd1,
        OP_XOR  = 4'd2,
        OP_SLL  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SRA  = 4'd6,
        OP_MUL  = 4'd7,
        OP_DIV  = 4'd8,
        OP_DIVU = 4'd9,
        OP_REM  = 4'd10,
        OP_REMU = 4'd11
    } alu_op_e;

    localparam logic [1:0] ALUOP_LS = 2'b00;
    localparam logic [1:0] ALUOP_BR = 2'b01;
    localparam logic [1:0] ALUOP_R  = 2'b10;
    localparam logic [1:0] ALUOP_I  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;

    localparam logic [9:0] FN_ADD  = {F7_BASE,   3'b000};
    localparam logic [9:0] FN_SLL  = {F7_BASE,   3'b001};
    localparam logic [9:0] FN_XOR  = {F7_BASE,   3'b100};
    localparam logic [9:0] FN_AND  = {F7_BASE,   3'b111};
    localparam logic [9:0] FN_SUB  = {F7_ALT,    3'b000};
    localparam logic [9:0] FN_MUL  = {F7_MULDIV, 3'b000};
    localparam logic [9:0] FN_DIV  = {F7_MULDIV, 3'b100};
    localparam logic [9:0] FN_DIVU = {F7_MULDIV, 3'b101};
    localparam logic [9:0] FN_REM  = {F7_MULDIV, 3'b110};
    localparam logic [9:0] FN_REMU = {F7_MULDIV, 3'b111};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } ex_state_e;

    // True for the four operations that go through the divide engine.
    function automatic logic is_div_class(input alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational ALU-control decode: main-control op class plus funct field
// into a single alu_op_e.
//   ALUOp_i : op class from main control (LS/BR/R/I)
//   funct_i : {funct7, funct3}
//   op      : decoded operation (OP_NOP for anything unrecognised)
// -----------------------------------------------------------------------------
module alu_op_decode
    import exec_pkg::*;
(
    input  logic [1:0] ALUOp_i,
    input  logic [9:0] funct_i,
    output alu_op_e    op
);

    always_comb begin
        op = OP_NOP;
        case (ALUOp_i)
            ALUOP_LS: op = OP_ADD;
            ALUOP_BR: op = OP_SUB;
            ALUOP_I: begin
                // Immediate forms only look at funct3; funct7 bits carry
                // immediate/shamt-high data and are not decoded here.
                case (funct_i[2:0])
                    F3_ADDI: op = OP_ADD;
                    F3_SRAI: op = OP_SRA;
                    default: op = OP_NOP;
                endcase
            end
            ALUOP_R: begin
                case (funct_i)
                    FN_AND:  op = OP_AND;
                    FN_XOR:  op = OP_XOR;
                    FN_SLL:  op = OP_SLL;
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_MUL:  op = OP_MUL;
                    FN_DIV:  op = OP_DIV;
                    FN_DIVU: op = OP_DIVU;
                    FN_REM:  op = OP_REM;
                    FN_REMU: op = OP_REMU;
                    default: op = OP_NOP;
                endcase
            end
            default: op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/exec_alu_muldiv.sv
// -----------------------------------------------------------------------------
// exec_alu_muldiv
// EX-stage ALU: single-cycle simple ops, iterative shift-add multiply and
// restoring divide (one bit per cycle), with pipeline stall via ready_o.
//
// Handshake: an operation is accepted on a rising edge where
// valid_i & ready_o & !flush_i. ready_o is high only in IDLE. valid_o pulses
// for exactly one cycle with result_o; result_o holds its value otherwise.
// flush_i returns the unit to IDLE next cycle without producing a result.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   valid_i, ALUOp_i, funct_i, src1_i, src2_i : operation offer
//   flush_i     : abort in-flight op / block a same-cycle offer
//   ready_o     : unit can accept
//   valid_o     : result_o valid (one-cycle pulse)
//   result_o    : registered result
//   zero_o      : result_o == 0
//   dbg_state_o : current FSM state, for observation only
// -----------------------------------------------------------------------------
module exec_alu_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output ex_state_e       dbg_state_o
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_TOP = SHW'(XLEN - 1);

    ex_state_e       state;
    logic [SHW-1:0]  count;
    // a_q: multiplicand (MUL) / dividend shifting into quotient (DIV)
    // b_q: multiplier (MUL)   / divisor magnitude (DIV)
    // acc_q: product accumulator (MUL) / partial remainder (DIV)
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_q;
    logic            neg_quot_q;
    logic            neg_rem_q;
    logic            want_rem_q;

    alu_op_e dec_op;

    alu_op_decode u_decode (
        .ALUOp_i (ALUOp_i),
        .funct_i (funct_i),
        .op      (dec_op)
    );

    // ---------------- single-cycle datapath ----------------
    logic [XLEN-1:0] simple_res;
    always_comb begin
        simple_res = '0;
        case (dec_op)
            OP_AND:  simple_res = src1_i & src2_i;
            OP_XOR:  simple_res = src1_i ^ src2_i;
            OP_SLL:  simple_res = src1_i << src2_i[SHW-1:0];
            OP_ADD:  simple_res = src1_i + src2_i;
            OP_SUB:  simple_res = src1_i - src2_i;
            OP_SRA:  simple_res = $signed(src1_i) >>> src2_i[SHW-1:0];
            default: simple_res = '0;
        endcase
    end

    // ---------------- divide setup / special cases ----------------
    logic            div_op;
    logic            signed_div;
    logic            div_zero;
    logic            div_ovf;
    logic            s1_neg;
    logic            s2_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;

    always_comb begin
        div_op     = is_div_class(dec_op);
        signed_div = (dec_op == OP_DIV) || (dec_op == OP_REM);
        div_zero   = (src2_i == '0);
        div_ovf    = signed_div && (src1_i == MIN_VAL) && (src2_i == '1);
        s1_neg     = signed_div && src1_i[XLEN-1];
        s2_neg     = signed_div && src2_i[XLEN-1];
        a_mag      = s1_neg ? ('0 - src1_i) : src1_i;
        b_mag      = s2_neg ? ('0 - src2_i) : src2_i;
        special_res = '0;
        if (div_zero) begin
            special_res = ((dec_op == OP_DIV) || (dec_op == OP_DIVU)) ? '1 : src1_i;
        end else if (div_ovf) begin
            special_res = (dec_op == OP_DIV) ? src1_i : '0;
        end
    end

    // ---------------- iteration steps ----------------
    logic [XLEN-1:0] mul_acc_next;
    logic [XLEN:0]   r_shift;
    logic [XLEN:0]   r_sub;
    logic            r_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        mul_acc_next = acc_q + (b_q[0] ? a_q : '0);
        // Restoring step: bring in the next dividend bit, try subtracting.
        r_shift  = {acc_q, a_q[XLEN-1]};
        r_sub    = r_shift - {1'b0, b_q};
        r_ge     = ~r_sub[XLEN];
        rem_next = r_ge ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];
        quo_next = {a_q[XLEN-2:0], r_ge};
        quo_fix  = neg_quot_q ? ('0 - quo_next) : quo_next;
        rem_fix  = neg_rem_q  ? ('0 - rem_next) : rem_next;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            result_o   <= '0;
            count      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    if (valid_i && ready_o) begin
                        ready_o <= 1'b0;
                        if (dec_op == OP_MUL) begin
                            state <= ST_MUL;
                            a_q   <= src1_i;
                            b_q   <= src2_i;
                            acc_q <= '0;
                            count <= CNT_TOP;
                        end else if (div_op && !div_zero && !div_ovf) begin
                            state      <= ST_DIV;
                            a_q        <= a_mag;
                            b_q        <= b_mag;
                            acc_q      <= '0;
                            neg_quot_q <= s1_neg ^ s2_neg;
                            neg_rem_q  <= s1_neg;
                            want_rem_q <= (dec_op == OP_REM) || (dec_op == OP_REMU);
                            count      <= CNT_TOP;
                        end else begin
                            state    <= ST_DONE;
                            valid_o  <= 1'b1;
                            result_o <= div_op ? special_res : simple_res;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_acc_next;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    if (count == '0) begin
                        state    <= ST_DONE;
                        valid_o  <= 1'b1;
                        result_o <= mul_acc_next;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_DIV: begin
                    acc_q <= rem_next;
                    a_q   <= quo_next;
                    if (count == '0) begin
                        state    <= ST_DONE;
                        valid_o  <= 1'b1;
                        result_o <= want_rem_q ? rem_fix : quo_fix;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

    assign zero_o      = (result_o == '0);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_exec_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_exec_alu_muldiv
// Directed-vector bench for exec_alu_muldiv (XLEN=32) with hand-computed
// expected results and cycle-exact latency checks.
// -----------------------------------------------------------------------------
module tb_exec_alu_muldiv;
    import exec_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  ALUOp_i;
    logic [9:0]  funct_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;
    ex_state_e   dbg_state_o;

    int n_vec;
    int n_err;

    exec_alu_muldiv #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ALUOp_i     (ALUOp_i),
        .funct_i     (funct_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Offer one op in IDLE, scramble inputs after accept, check that valid_o
    // appears exactly lat edges after the accept edge, then the return to IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [9:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] exp);
        int bad;
        bad = 0;
        chk({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
        valid_i = 1'b1;
        ALUOp_i = op;
        funct_i = fn;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        funct_i = 10'($urandom_range(0, 1023));
        ALUOp_i = 2'($urandom_range(0, 3));
        for (int i = 0; i < lat; i++) begin
            if (valid_o || ready_o) bad++;
            @(posedge clk_i); #1;
        end
        if (lat > 0) chk({tag, "_stall"}, 32'(bad), 32'd0);
        chk({tag, "_vld"}, {31'b0, valid_o}, 32'd1);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_zero"}, {31'b0, zero_o}, {31'b0, (exp == 32'h0)});
        @(posedge clk_i); #1;
        chk({tag, "_end"}, {30'b0, valid_o, ready_o}, 32'd1);
        chk({tag, "_hold"}, result_o, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        logic [31:0] last_res;
        n_vec   = 0;
        n_err   = 0;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ALUOp_i = 2'b00;
        funct_i = 10'h0;
        src1_i  = 32'h0;
        src2_i  = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero", {31'b0, zero_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Reset in the middle of a divide.
        run_op("add_pre", 2'b00, 10'h0, 32'd5, 32'd7, 0, 32'd12);
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = {7'b0000001, 3'b100};
        src1_i = 32'd100; src2_i = 32'd7;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("middiv_busy", {31'b0, ready_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("middiv_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("middiv_rst_ready", {31'b0, ready_o}, 32'd1);
        chk("middiv_rst_result", result_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_op("add_5_7", 2'b00, 10'h0, 32'd5, 32'd7, 0, 32'd12);

        // Simple ops.
        run_op("sub_r",  2'b10, {7'b0100000, 3'b000}, 32'd3, 32'd5, 0, 32'hFFFF_FFFE);
        run_op("sub_br", 2'b01, 10'h3FF, 32'd9, 32'd9, 0, 32'h0);
        run_op("and",    2'b10, {7'b0000000, 3'b111}, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 32'h00F0_1200);
        run_op("xor",    2'b10, {7'b0000000, 3'b100}, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555);
        run_op("sll",    2'b10, {7'b0000000, 3'b001}, 32'h0000_0003, 32'hFFFF_FFE4, 0, 32'h0000_0030);
        run_op("add_r",  2'b10, {7'b0000000, 3'b000}, 32'hFFFF_FFFF, 32'd2, 0, 32'd1);
        run_op("addi",   2'b11, {7'b0101010, 3'b000}, 32'd40, 32'hFFFF_FFF6, 0, 32'd30);
        run_op("srai",   2'b11, {7'b0100000, 3'b101}, 32'h8000_0000, 32'd4, 0, 32'hF800_0000);
        run_op("nop_i",  2'b11, {7'b0000000, 3'b010}, 32'd1, 32'd2, 0, 32'h0);
        run_op("nop_r",  2'b10, {7'b0000010, 3'b000}, 32'd1, 32'd2, 0, 32'h0);

        // Multiply.
        run_op("mul_big", 2'b10, {7'b0000001, 3'b000}, 32'h0001_0000, 32'h0001_0001, 32, 32'h0001_0000);
        run_op("mul_neg", 2'b10, {7'b0000001, 3'b000}, 32'hFFFF_FFFD, 32'd7, 32, 32'hFFFF_FFEB);

        // Divide family.
        run_op("div_m7_2",  2'b10, {7'b0000001, 3'b100}, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD);
        run_op("rem_m7_2",  2'b10, {7'b0000001, 3'b110}, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF);
        run_op("divu_16",   2'b10, {7'b0000001, 3'b101}, 32'hFFFF_FFFF, 32'd16, 32, 32'h0FFF_FFFF);
        run_op("remu_100_7",2'b10, {7'b0000001, 3'b111}, 32'd100, 32'd7, 32, 32'd2);
        run_op("div_20_m3", 2'b10, {7'b0000001, 3'b100}, 32'd20, 32'hFFFF_FFFD, 32, 32'hFFFF_FFFA);

        // Special cases resolve in one cycle.
        run_op("div_by0",  2'b10, {7'b0000001, 3'b100}, 32'd123, 32'd0, 0, 32'hFFFF_FFFF);
        run_op("divu_by0", 2'b10, {7'b0000001, 3'b101}, 32'd123, 32'd0, 0, 32'hFFFF_FFFF);
        run_op("rem_by0",  2'b10, {7'b0000001, 3'b110}, 32'd123, 32'd0, 0, 32'd123);
        run_op("div_ovf",  2'b10, {7'b0000001, 3'b100}, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
        run_op("rem_ovf",  2'b10, {7'b0000001, 3'b110}, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0);
        run_op("add_last", 2'b00, 10'h0, 32'h1234_0000, 32'h0000_5678, 0, 32'h1234_5678);
        last_res = 32'h1234_5678;

        // Flush at cycle N+10 of a multiply.
        valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = {7'b0000001, 3'b000};
        src1_i = 32'd3; src2_i = 32'd5;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_ready", {31'b0, ready_o}, 32'd1);
        chk("flush_state", {30'b0, dbg_state_o}, {30'b0, ST_IDLE});
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) cnt++;
            @(posedge clk_i); #1;
        end
        chk("flush_no_valid", 32'(cnt), 32'd0);
        chk("flush_hold", result_o, last_res);

        // Flush together with an offer: the offer must be ignored.
        flush_i = 1'b1; valid_i = 1'b1; ALUOp_i = 2'b00;
        src1_i = 32'd1; src2_i = 32'd1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flushv_ready", {31'b0, ready_o}, 32'd1);
        chk("flushv_valid", {31'b0, valid_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("flushv_valid2", {31'b0, valid_o}, 32'd0);
        chk("flushv_hold", result_o, last_res);

        // The unit still works after the flushes.
        run_op("add_after", 2'b00, 10'h0, 32'd100, 32'd23, 0, 32'd123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
